// File: rtl/cursor_packet_rx.sv
// UART receiver for 5-byte cursor packets: SYNC, BTN, DX, DY, CHK (CHK = BTN^DX^DY).
// A byte FSM feeds a packet FSM. Every output is a registered pulse or a held value.
module cursor_packet_rx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       pkt_valid,
    output logic [1:0] buttons,
    output logic [7:0] dx,
    output logic [7:0] dy,
    output logic       frame_err,
    output logic       chk_err,
    output logic       pkt_timeout
);
    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL    = CW'(CLKS_PER_BIT - 1);
    localparam int            TO_LIM  = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int            TW      = $clog2(TO_LIM);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_LIM - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} bstate_t;
    typedef enum logic [2:0] {P_SYNC, P_BTN, P_DX, P_DY, P_CHK} pstate_t;

    logic          rx_m, rxs;
    bstate_t       state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, sh_n;
    logic          byte_stb, ferr;

    pstate_t       pstate, pstate_n;
    logic [TW-1:0] gap, gap_n;
    logic [7:0]    btn_h, dx_h, dy_h;
    logic          pv_n, ce_n, to_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rxs  <= 1'b1;
        end else begin
            rx_m <= rx;
            rxs  <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= sh_n;
        end
    end

    // Start is re-checked at mid-bit; every later sample lands mid-bit too.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + CW'(1);
        bit_n    = bit_idx;
        sh_n     = shreg;
        byte_stb = 1'b0;
        ferr     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) state_n = START;
            end
            START: if (cnt == HALF) begin
                cnt_n   = '0;
                bit_n   = '0;
                state_n = rxs ? IDLE : DATA;
            end
            DATA: if (cnt == FULL) begin
                cnt_n = '0;
                sh_n  = {rxs, shreg[7:1]};
                bit_n = bit_idx + 3'd1;
                if (bit_idx == 3'd7) state_n = STOP;
            end
            STOP: if (cnt == FULL) begin
                cnt_n = '0;
                if (rxs) begin
                    byte_stb = 1'b1;
                    state_n  = IDLE;
                end else begin
                    ferr    = 1'b1;
                    state_n = BREAK;
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A byte strobe takes priority over the idle-gap timeout.
    always_comb begin
        pstate_n = pstate;
        gap_n    = gap;
        pv_n     = 1'b0;
        ce_n     = 1'b0;
        to_n     = 1'b0;
        if (byte_stb) begin
            gap_n = '0;
            case (pstate)
                P_SYNC: if (shreg == SYNC_BYTE) pstate_n = P_BTN;
                P_BTN:  pstate_n = P_DX;
                P_DX:   pstate_n = P_DY;
                P_DY:   pstate_n = P_CHK;
                P_CHK: begin
                    if (shreg == (btn_h ^ dx_h ^ dy_h)) pv_n = 1'b1;
                    else                                 ce_n = 1'b1;
                    pstate_n = P_SYNC;
                end
                default: pstate_n = P_SYNC;
            endcase
        end else if (ferr || pstate == P_SYNC) begin
            gap_n    = '0;
            pstate_n = P_SYNC;
        end else if (state == IDLE) begin
            if (gap == TO_LAST) begin
                to_n     = 1'b1;
                gap_n    = '0;
                pstate_n = P_SYNC;
            end else begin
                gap_n = gap + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pstate      <= P_SYNC;
            gap         <= '0;
            btn_h       <= '0;
            dx_h        <= '0;
            dy_h        <= '0;
            pkt_valid   <= 1'b0;
            chk_err     <= 1'b0;
            pkt_timeout <= 1'b0;
            frame_err   <= 1'b0;
            buttons     <= '0;
            dx          <= '0;
            dy          <= '0;
        end else begin
            pstate      <= pstate_n;
            gap         <= gap_n;
            pkt_valid   <= pv_n;
            chk_err     <= ce_n;
            pkt_timeout <= to_n;
            frame_err   <= ferr;
            if (byte_stb && pstate == P_BTN) btn_h <= shreg;
            if (byte_stb && pstate == P_DX)  dx_h  <= shreg;
            if (byte_stb && pstate == P_DY)  dy_h  <= shreg;
            if (pv_n) begin
                buttons <= btn_h[1:0];
                dx      <= dx_h;
                dy      <= dy_h;
            end
        end
    end
endmodule

// File: tb/tb_cursor_packet_rx.sv
// Directed bench for cursor_packet_rx at 16 clocks per bit; pulses are tallied at negedge.
module tb_cursor_packet_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       pkt_valid, frame_err, chk_err, pkt_timeout;
    logic [1:0] buttons;
    logic [7:0] dx, dy;

    int errors = 0;
    int checks = 0;
    int n_pv = 0, n_fe = 0, n_ce = 0, n_to = 0, n_excl = 0;
    int b_pv, b_fe, b_ce, b_to;

    cursor_packet_rx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5), .TIMEOUT_BITS(20)) dut (
        .clk(clk), .rst(rst), .rx(rx), .pkt_valid(pkt_valid), .buttons(buttons),
        .dx(dx), .dy(dy), .frame_err(frame_err), .chk_err(chk_err), .pkt_timeout(pkt_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_pv += int'(pkt_valid);
        n_fe += int'(frame_err);
        n_ce += int'(chk_err);
        n_to += int'(pkt_timeout);
        if (int'(pkt_valid) + int'(frame_err) + int'(chk_err) + int'(pkt_timeout) > 1) n_excl++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (CPB) @(posedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic send_pkt(input logic [7:0] b0, b1, b2, b3, b4);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
        send_byte(b4, 1'b1);
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic mark;
        @(negedge clk);
        b_pv = n_pv; b_fe = n_fe; b_ce = n_ce; b_to = n_to;
        @(posedge clk);
    endtask

    task automatic check_pulses(input string tag, input int pv, fe, ce, to);
        @(negedge clk);
        check({tag, "_pkt_valid"},   n_pv - b_pv, pv);
        check({tag, "_frame_err"},   n_fe - b_fe, fe);
        check({tag, "_chk_err"},     n_ce - b_ce, ce);
        check({tag, "_pkt_timeout"}, n_to - b_to, to);
    endtask

    task automatic check_out(input string tag, input logic [1:0] bt, input logic [7:0] x, y);
        check({tag, "_buttons"}, 32'(buttons), 32'(bt));
        check({tag, "_dx"},      32'(dx),      32'(x));
        check({tag, "_dy"},      32'(dy),      32'(y));
    endtask

    initial begin
        // reset, then quiet line
        repeat (2) @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_out("reset", 2'b00, 8'h00, 8'h00);
        check("reset_pulses", {pkt_valid, frame_err, chk_err, pkt_timeout}, 4'b0000);
        mark();
        repeat (1000) @(posedge clk);
        check_pulses("idle", 0, 0, 0, 0);

        // good packet
        mark();
        send_pkt(8'hA5, 8'h01, 8'h05, 8'hFB, 8'hFF);
        check_pulses("good", 1, 0, 0, 0);
        check_out("good", 2'b01, 8'h05, 8'hFB);

        // bad checksum: outputs held
        mark();
        send_pkt(8'hA5, 8'h02, 8'h10, 8'h20, 8'h00);
        check_pulses("badchk", 0, 0, 1, 0);
        check_out("badchk", 2'b01, 8'h05, 8'hFB);

        // framing error inside packet, then recovery
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h7F, 1'b0);
        rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        check("frame_outputs_held", 32'({buttons, dx, dy}), 32'({2'b01, 8'h05, 8'hFB}));
        send_pkt(8'hA5, 8'h03, 8'h7F, 8'h80, 8'hFC);
        check_pulses("frame", 1, 1, 0, 0);
        check_out("frame", 2'b11, 8'h7F, 8'h80);

        // glitch rejection and resync through junk bytes
        mark();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h7E, 1'b1);
        send_pkt(8'hA5, 8'h00, 8'h01, 8'h01, 8'h00);
        check_pulses("glitch", 1, 0, 0, 0);
        check_out("glitch", 2'b00, 8'h01, 8'h01);

        // sync value used as data, not a resync
        mark();
        send_pkt(8'hA5, 8'hA5, 8'h01, 8'hA4, 8'h00);
        check_pulses("syncdata", 1, 0, 0, 0);
        check_out("syncdata", 2'b01, 8'h01, 8'hA4);

        // idle-gap timeout
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (400) @(posedge clk);
        check_pulses("timeout_gap", 0, 0, 0, 1);
        send_pkt(8'hA5, 8'h00, 8'h02, 8'hFE, 8'hFC);
        check_pulses("timeout", 1, 0, 0, 1);
        check_out("timeout", 2'b00, 8'h02, 8'hFE);

        // reset mid-byte, mid-packet
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        rx = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_out("midrst", 2'b00, 8'h00, 8'h00);
        repeat (2 * CPB) @(posedge clk);
        send_pkt(8'hA5, 8'h02, 8'h03, 8'h04, 8'h05);
        check_pulses("midrst", 1, 0, 0, 0);
        check_out("midrst_pkt", 2'b10, 8'h03, 8'h04);

        @(negedge clk);
        check("exclusive_pulses", n_excl, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
